fft_bitrev_reorder: RTL and testbench

- Sink at the output end of the 16-point radix-2^2 SDF FFT pipeline.
- Accepts the FFT's bit-reversed-order output stream (re/im + valid, no backpressure) into a ping-pong buffer.
- Replays each frame in natural order (X[0]..X[15]) over a valid/ready handshake, with a frame-end marker and bin index.
- Downstream blocks (magnitude, framing, test capture) see ordered, flow-controlled frames.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_pingpong_bank.sv | 33 +++
 rtl/fft_bitrev_reorder.sv | 134 +++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample type and bit-reversal helper for the FFT output reorder path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fft_pkg;

  localparam int WIDTH    = 16;
  localparam int N_POINTS = 16;
  localparam int LOG2N    = 4;

  // One complex FFT bin as stored in the reorder buffer (re in the upper half).
  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } sample_t;

  // Reverse the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx, input int nbits);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      if (i < nbits && nbits <= LOG2N) begin
        r[i] = idx[nbits-1-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// Two-bank register file: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller decides when to write and what to read.
module fft_pingpong_bank
  import fft_pkg::*;
#(
  parameter int DW    = 2 * fft_pkg::WIDTH,
  parameter int DEPTH = fft_pkg::N_POINTS,
  parameter int AW    = fft_pkg::LOG2N
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  // Contents are deliberately not reset; the full flags in the parent guard reads.
  logic [DW-1:0] mem [2][DEPTH];

  // Single write port into the selected bank.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural order via a ping-pong buffer.
// Latency: bin 0 is presented one edge after the edge that captures the 16th input sample.
// Backpressure: input cannot stall; a frame meeting a still-full bank is dropped whole (sticky overflow).
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH    = fft_pkg::WIDTH,
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int LOG2N    = fft_pkg::LOG2N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] fft_re,
  input  logic signed [WIDTH-1:0] fft_im,
  input  logic                    fft_valid,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [LOG2N-1:0]        out_index,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    overflow
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  logic [LOG2N-1:0]   wr_cnt;
  logic [LOG2N-1:0]   rd_cnt;
  logic               wr_bank;
  logic               rd_bank;
  logic               drop;
  logic [1:0]         bank_full;

  logic               frame_start;
  logic               drop_cur;
  logic               wr_en;
  logic               wr_commit;
  logic               rd_load;
  logic               rd_fire;
  logic               rd_release;
  logic [LOG2N-1:0]   wr_addr;
  logic [2*WIDTH-1:0] wr_data;
  logic [2*WIDTH-1:0] rd_data;
  logic [WIDTH-1:0]   rd_re;
  logic [WIDTH-1:0]   rd_im;

  // The drop decision is taken on the first sample of a frame and then held for the rest of it.
  assign frame_start = (wr_cnt == '0);
  assign drop_cur    = frame_start ? bank_full[wr_bank] : drop;
  assign wr_en       = fft_valid && !drop_cur;
  assign wr_commit   = fft_valid && (wr_cnt == LAST_IDX) && !drop_cur;
  assign wr_addr     = fft_pkg::bitrev(wr_cnt, LOG2N);
  assign wr_data     = {fft_re, fft_im};

  // Output register may take a new sample when empty or when the current one is consumed.
  assign rd_load    = !out_valid || out_ready;
  assign rd_fire    = rd_load && bank_full[rd_bank];
  assign rd_release = rd_fire && (rd_cnt == LAST_IDX);
  assign {rd_re, rd_im} = rd_data;

  fft_pingpong_bank #(
    .DW    (2 * WIDTH),
    .DEPTH (N_POINTS),
    .AW    (LOG2N)
  ) u_bank (
    .clk     (clk),
    .we      (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_bank (rd_bank),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  // Write-side counter, bank pointer, per-frame drop flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else if (fft_valid) begin
      wr_cnt <= wr_cnt + 1'b1;
      drop   <= drop_cur;
      if (frame_start && bank_full[wr_bank]) begin
        overflow <= 1'b1;
      end
      if (wr_commit) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Full flags: set by a completed write frame, cleared once its last bin is loaded for output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_full <= 2'b00;
    end else begin
      if (wr_commit) begin
        bank_full[wr_bank] <= 1'b1;
      end
      if (rd_release) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

  // Natural-order read pointer and output register; holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (rd_fire) begin
      out_re    <= rd_re;
      out_im    <= rd_im;
      out_index <= rd_cnt;
      out_last  <= (rd_cnt == LAST_IDX);
      out_valid <= 1'b1;
      rd_cnt    <= rd_cnt + 1'b1;
      if (rd_release) begin
        rd_bank <= ~rd_bank;
      end
    end else if (rd_load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: frame-level reorder model plus directed scenarios.
// Latency: checks first output one edge after the 16th input sample.
// Backpressure: exercises stalls, overflow drops and reset mid-frame.
module tb_fft_bitrev_reorder;

  typedef struct {
    int re;
    int im;
    int idx;
    int last;
  } exp_t;

  logic               clk;
  logic               rst;
  logic signed [15:0] fft_re;
  logic signed [15:0] fft_im;
  logic               fft_valid;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic [3:0]         out_index;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               overflow;

  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];
  int   acc_re[16];
  int   acc_im[16];

  fft_bitrev_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .fft_re    (fft_re),
    .fft_im    (fft_im),
    .fft_valid (fft_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bit reversal of a 4-bit index done arithmetically.
  function automatic int tb_rev(input int k);
    int r;
    int v;
    r = 0;
    v = k;
    for (int i = 0; i < 4; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Stream position p of a frame carries (base+p, -(base+p)); bin k holds position rev(k).
  task automatic push_frame(input int base);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.re   = base + tb_rev(k);
      e.im   = -(base + tb_rev(k));
      e.idx  = k;
      e.last = (k == 15) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_frame(input int base, input int gap_after, input int gap_len);
    for (int j = 0; j < 16; j++) begin
      fft_valid = 1'b1;
      fft_re    = 16'(base + j);
      fft_im    = 16'(-(base + j));
      tick();
      if (j == gap_after) begin
        fft_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check("gap_no_output", int'(out_valid), 0);
        end
      end
    end
    fft_valid = 1'b0;
  endtask

  // Drain the expected queue; mode 1 applies a 1,0,0,1 ready pattern.
  task automatic drain(input string name, input int mode, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (mode == 1) out_ready = (n % 4 == 0 || n % 4 == 3);
      else out_ready = 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b1;
    check(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  // Compare process: every cycle the DUT output is checked against the head of the model queue.
  initial begin
    exp_t e;
    int   have_prev;
    int   p_valid;
    int   p_ready;
    int   p_re;
    int   p_im;
    int   p_idx;
    have_prev = 0;
    p_valid = 0; p_ready = 0; p_re = 0; p_im = 0; p_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        have_prev = 0;
        continue;
      end
      if (have_prev != 0 && p_valid != 0 && p_ready == 0) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_re", int'(out_re), p_re);
        check("stall_im", int'(out_im), p_im);
        check("stall_idx", int'(out_index), p_idx);
      end
      if (exp_q.size() == 0) begin
        check("spurious_valid", int'(out_valid), 0);
      end else if (out_valid) begin
        e = exp_q[0];
        check("out_re", int'(out_re), e.re);
        check("out_im", int'(out_im), e.im);
        check("out_index", int'(out_index), e.idx);
        check("out_last", int'(out_last), e.last);
        if (out_ready) begin
          acc_re[out_index] = int'(out_re);
          acc_im[out_index] = int'(out_im);
          void'(exp_q.pop_front());
        end
      end
      have_prev = 1;
      p_valid   = int'(out_valid);
      p_ready   = int'(out_ready);
      p_re      = int'(out_re);
      p_im      = int'(out_im);
      p_idx     = int'(out_index);
    end
  end

  initial begin
    int n;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b0;
    fft_valid = 1'b0;
    fft_re    = '0;
    fft_im    = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      acc_re[i] = 999;
      acc_im[i] = 999;
    end
    repeat (3) tick();

    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_index", int'(out_index), 0);
    check("rst_out_re", int'(out_re), 0);
    check("rst_out_im", int'(out_im), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b1;
    tick();

    // Single frame with latency check and hand-computed bin placement.
    out_ready = 1'b1;
    push_frame(0);
    feed_frame(0, -1, 0);
    check("lat_not_yet", int'(out_valid), 0);
    tick();
    check("lat_first_valid", int'(out_valid), 1);
    check("lat_first_index", int'(out_index), 0);
    drain("single_drain", 0, 100);
    check("bin1_re", acc_re[1], 8);
    check("bin3_re", acc_re[3], 12);
    check("bin3_im", acc_im[3], -12);
    check("bin14_re", acc_re[14], 7);
    check("bin15_re", acc_re[15], 15);

    // Backpressure with a 1,0,0,1 ready pattern.
    push_frame(1000);
    feed_frame(1000, -1, 0);
    drain("bp_drain", 1, 200);

    // Three back-to-back frames with ready held high.
    push_frame(2000);
    push_frame(3000);
    push_frame(4000);
    feed_frame(2000, -1, 0);
    feed_frame(3000, -1, 0);
    feed_frame(4000, -1, 0);
    drain("b2b_drain", 0, 200);
    check("b2b_no_overflow", int'(overflow), 0);

    // Input gap of 5 cycles after sample 7.
    push_frame(500);
    feed_frame(500, 7, 5);
    drain("gap_drain", 0, 100);

    // Overflow: both banks fill, the third frame is dropped.
    out_ready = 1'b0;
    push_frame(6000);
    push_frame(7000);
    feed_frame(6000, -1, 0);
    feed_frame(7000, -1, 0);
    feed_frame(8000, -1, 0);
    tick();
    check("ovf_set", int'(overflow), 1);
    drain("ovf_drain", 0, 200);
    check("ovf_sticky", int'(overflow), 1);

    // Reset while bin 6 is on the output, then a fresh frame.
    out_ready = 1'b1;
    push_frame(100);
    feed_frame(100, -1, 0);
    n = 0;
    while (!(out_valid && out_index == 4'd6) && n < 50) begin
      tick();
      n++;
    end
    check("rst_wait_bin6", int'(out_valid && out_index == 4'd6), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_overflow", int'(overflow), 0);
    tick();
    push_frame(200);
    feed_frame(200, -1, 0);
    drain("post_rst_drain", 0, 100);
    check("post_rst_bin1", acc_re[1], 208);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
